dot_led_axil_regbank: RTL

//  Parametrised AXI4-Lite slave register bank for the dot-LED VDMA control path.

---
 rtl/dot_led_pkg.sv | 28 ++
 rtl/dot_led_axil_wr_merge.sv | 21 ++
 rtl/dot_led_axil_regbank.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/dot_led_pkg.sv
// Shared constants for the dot-LED control path: AXI response codes, the register
// map used by the VDMA logic and by software, and a constant-safe log2 helper.
package dot_led_pkg;

    typedef enum logic [1:0] {
        AXI_RESP_OKAY   = 2'b00,
        AXI_RESP_SLVERR = 2'b10
    } axi_resp_e;

    localparam int REG_CTRL      = 0;
    localparam int REG_STATUS    = 1;
    localparam int REG_FB_ADDR   = 2;
    localparam int REG_FB_STRIDE = 3;
    localparam int REG_SCAN_CFG  = 4;
    localparam int REG_IRQ_EN    = 5;
    localparam int REG_IRQ_STAT  = 6;
    localparam int REG_VERSION   = 7;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/dot_led_axil_wr_merge.sv
// Byte-strobe merge: every byte lane with its strobe set takes the new data,
// every other lane keeps the old register contents.
module dot_led_axil_wr_merge #(
    parameter int DW = 32
) (
    input  logic [DW-1:0]   old_data,
    input  logic [DW-1:0]   new_data,
    input  logic [DW/8-1:0] strb,
    output logic [DW-1:0]   merged
);

    always_comb begin
        merged = old_data;
        for (int b = 0; b < DW / 8; b++) begin
            if (strb[b]) begin
                merged[b*8 +: 8] = new_data[b*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/dot_led_axil_regbank.sv
// AXI4-Lite register bank for the dot-LED VDMA control path: N registers of DW bits,
// optional read-only status slots, byte strobes, per-register write pulses, SLVERR decode.
module dot_led_axil_regbank
    import dot_led_pkg::*;
#(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 8,
    parameter int          NUM_REGS           = 8,
    parameter logic [63:0] RO_MASK            = 64'h0
) (
    input  logic                             S_AXI_ACLK,
    input  logic                             S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]    S_AXI_AWADDR,
    input  logic                             S_AXI_AWVALID,
    output logic                             S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]    S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]  S_AXI_WSTRB,
    input  logic                             S_AXI_WVALID,
    output logic                             S_AXI_WREADY,
    output logic [1:0]                       S_AXI_BRESP,
    output logic                             S_AXI_BVALID,
    input  logic                             S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]    S_AXI_ARADDR,
    input  logic                             S_AXI_ARVALID,
    output logic                             S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]    S_AXI_RDATA,
    output logic [1:0]                       S_AXI_RRESP,
    output logic                             S_AXI_RVALID,
    input  logic                             S_AXI_RREADY,
    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_out,
    input  logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] status_in,
    output logic [NUM_REGS-1:0]              wr_pulse
);

    localparam int DW       = C_S_AXI_DATA_WIDTH;
    localparam int AW       = C_S_AXI_ADDR_WIDTH;
    localparam int SW       = DW / 8;
    localparam int ADDR_LSB = clog2(SW);
    localparam int IDX_W    = AW - ADDR_LSB;
    localparam int IDX_W1   = IDX_W + 1;
    localparam logic [IDX_W:0] NREGS_W = IDX_W1'(NUM_REGS);

    logic                live;
    logic                aw_held, w_held, bvalid, rvalid;
    logic [IDX_W-1:0]    aw_idx, ar_idx;
    logic [DW-1:0]       wdata_q, rdata, wr_old, wr_merged, rd_value;
    logic [SW-1:0]       wstrb_q;
    logic [1:0]          bresp, rresp;
    logic [NUM_REGS-1:0] pulse, is_ro;
    logic [DW-1:0]       regs   [NUM_REGS];
    logic [DW-1:0]       rd_src [NUM_REGS];
    logic                aw_in_range, ar_in_range;
    logic                unused_ok;

    // Valid/ready: a beat transfers on the rising edge where both are high. Readies are
    // held low in reset and in the first cycle after, and only one write and one read
    // may be outstanding; BVALID/RVALID hold with stable payload until their ready.
    assign S_AXI_AWREADY = live && !aw_held && !bvalid;
    assign S_AXI_WREADY  = live && !w_held && !bvalid;
    assign S_AXI_ARREADY = live && !rvalid;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = bresp;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RRESP   = rresp;
    assign S_AXI_RDATA   = rdata;
    assign wr_pulse      = pulse;

    // Sub-word offset bits never select anything.
    assign unused_ok = &{1'b0, S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0], status_in};

    assign ar_idx      = S_AXI_ARADDR[AW-1:ADDR_LSB];
    assign aw_in_range = ({1'b0, aw_idx} < NREGS_W);
    assign ar_in_range = ({1'b0, ar_idx} < NREGS_W);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        assign is_ro[g]              = RO_MASK[g];
        assign rd_src[g]             = RO_MASK[g] ? status_in[g*DW +: DW] : regs[g];
        assign reg_out[g*DW +: DW]   = RO_MASK[g] ? '0 : regs[g];
    end

    always_comb begin
        wr_old   = '0;
        rd_value = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (aw_idx == IDX_W'(i)) wr_old = regs[i];
            if (ar_idx == IDX_W'(i)) rd_value = rd_src[i];
        end
    end

    dot_led_axil_wr_merge #(.DW(DW)) u_wr_merge (
        .old_data (wr_old),
        .new_data (wdata_q),
        .strb     (wstrb_q),
        .merged   (wr_merged)
    );

    // Write channel: AW and W latch independently; the cycle after both are held commits.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            live    <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_idx  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            bvalid  <= 1'b0;
            bresp   <= AXI_RESP_OKAY;
            pulse   <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            live  <= 1'b1;
            pulse <= '0;
            if (S_AXI_AWVALID && S_AXI_AWREADY) begin
                aw_held <= 1'b1;
                aw_idx  <= S_AXI_AWADDR[AW-1:ADDR_LSB];
            end
            if (S_AXI_WVALID && S_AXI_WREADY) begin
                w_held  <= 1'b1;
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (aw_held && w_held) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                bresp   <= aw_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (aw_in_range && aw_idx == IDX_W'(i) && !is_ro[i]) begin
                        regs[i]  <= wr_merged;
                        pulse[i] <= 1'b1;
                    end
                end
            end else if (bvalid && S_AXI_BREADY) begin
                bvalid <= 1'b0;
            end
        end
    end

    // Read channel: data and response are captured at the AR handshake, so a same-cycle
    // commit to the same register is seen as the pre-write value.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid <= 1'b0;
            rdata  <= '0;
            rresp  <= AXI_RESP_OKAY;
        end else if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            rvalid <= 1'b1;
            rdata  <= ar_in_range ? rd_value : '0;
            rresp  <= ar_in_range ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        end else if (rvalid && S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end

endmodule
